// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one LSB-first bit-slice per clock under an IDLE/RUN/DONE controller.
// Define SERIAL_ADD_SUB_EN to add the sub port (A-B via inverted B and carry-in 1).
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             load;
  logic             step;
  logic             last;
  logic             bit_a;
  logic             bit_b;
  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             c_nxt;
  logic             c_init;

`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q;

  assign bit_b  = b_sr[0] ^ sub_q;
  assign c_init = sub;
`else
  assign bit_b  = b_sr[0];
  assign c_init = 1'b0;
`endif

  // Bit-slice: two half-adders plus an OR for the carry.
  assign bit_a = a_sr[0];
  assign ha1_s = bit_a ^ bit_b;
  assign ha1_c = bit_a & bit_b;
  assign ha2_s = ha1_s ^ c;
  assign ha2_c = ha1_s & c;
  assign c_nxt = ha1_c | ha2_c;

  always_comb begin
    psum_nxt      = psum;
    psum_nxt[cnt] = ha2_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status; the counter parks on the last bit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        psum  <= '0;
        cnt   <= '0;
        c     <= c_init;
`ifdef SERIAL_ADD_SUB_EN
        sub_q <= sub;
`endif
      end else if (step) begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        psum <= psum_nxt;
        c    <= c_nxt;
        if (last) begin
          sum   <= psum_nxt;
          carry <= c_nxt;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
